mux_rr_arbiter: RTL and testbench

- Shares one 4:1 data mux between four requesters using a round-robin arbiter with grant hold.
- Each requester raises req and holds it while it owns the mux.
- The arbiter registers a one-hot grant and the matching 2-bit select, and drives the muxed data out.
- Sits between four producer blocks and a single shared consumer path.

---
 rtl/mux_rr_arbiter_pkg.sv | 22 ++
 rtl/mux_rr_arbiter_rr_pick4.sv | 29 ++
 rtl/mux_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encodings,
// requester count, mux select codes and a one-hot decode helper.
package mux_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  // Turns a requester index into its one-hot grant pattern
  function automatic logic [NUM_REQ-1:0] oneHot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: finds the first set request bit after
// the pointer, wrapping 3 -> 0, with the pointer position itself checked last.
module rr_pick4
  import mux_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [1:0]         pointer_i,
  output logic               found_o,
  output logic [1:0]         idx_o
);

  logic [1:0] cand;

  // Scan from the farthest slot to the nearest so the slot right after the
  // pointer wins when several requests are set
  always_comb begin
    found_o = 1'b0;
    idx_o   = 2'd0;
    cand    = 2'd0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = pointer_i + 2'(k);
      if (req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with grant hold sharing one 4:1 data mux between four
// requesters. Grant, select and valid are registered; y is the combinational
// mux output gated by valid.
// Optional build macro MUX_ARB_TIMEOUT_EN: adds a hold counter that preempts
// a holder after HOLD_MAX cycles when another requester is waiting.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  a,
  input  logic [DATA_W-1:0]  b,
  input  logic [DATA_W-1:0]  c,
  input  logic [DATA_W-1:0]  d,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         sel,
  output logic               valid,
  output logic [DATA_W-1:0]  y
);

  // Reject an out-of-range hold limit at elaboration time
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : gHoldMaxRange
    $error("mux_rr_arbiter: HOLD_MAX must be in 1..255");
  end

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         sel_q, sel_d;
  logic               valid_q, valid_d;
  logic [1:0]         last_q, last_d;

  logic [NUM_REQ-1:0] pickReq;
  logic               pickFound;
  logic [1:0]         pickIdx;
  logic               holderReq;
  logic               preempt;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX - 1);
  logic [7:0] holdCnt_q, holdCnt_d;
`endif

  // While busy the holder is masked out so the picker only sees competitors;
  // the pointer equals the holder index then, so the search starts after it
  assign pickReq   = (state_q == ST_BUSY) ? (req & ~grant_q) : req;
  assign holderReq = |(req & grant_q);

  rr_pick4 uPick (
    .req_i     (pickReq),
    .pointer_i (last_q),
    .found_o   (pickFound),
    .idx_o     (pickIdx)
  );

  // Preemption only exists with the timeout build; otherwise the holder keeps
  // the grant until it drops its request
`ifdef MUX_ARB_TIMEOUT_EN
  assign preempt = (holdCnt_q >= HOLD_LIM);
`else
  assign preempt = 1'b0;
`endif

  // Next-state decision: initial grant from idle, handoff or release when the
  // holder drops (or times out), otherwise hold
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    last_d    = last_q;
`ifdef MUX_ARB_TIMEOUT_EN
    holdCnt_d = holdCnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pickFound) begin
          state_d   = ST_BUSY;
          grant_d   = oneHot4(pickIdx);
          sel_d     = pickIdx;
          valid_d   = 1'b1;
          last_d    = pickIdx;
`ifdef MUX_ARB_TIMEOUT_EN
          holdCnt_d = 8'd0;
`endif
        end
      end
      ST_BUSY: begin
        if ((!holderReq || preempt) && pickFound) begin
          grant_d   = oneHot4(pickIdx);
          sel_d     = pickIdx;
          last_d    = pickIdx;
`ifdef MUX_ARB_TIMEOUT_EN
          holdCnt_d = 8'd0;
`endif
        end else if (!holderReq) begin
          state_d = ST_IDLE;
          grant_d = '0;
          valid_d = 1'b0;
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (holdCnt_q != 8'hFF) begin
            holdCnt_d = holdCnt_q + 8'd1;
          end
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Arbiter state and registered outputs; reset clears everything at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      sel_q     <= SEL_A;
      valid_q   <= 1'b0;
      last_q    <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
      holdCnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
`ifdef MUX_ARB_TIMEOUT_EN
      holdCnt_q <= holdCnt_d;
`endif
    end
  end

  // Shared data mux; output is forced to zero when nobody holds the grant
  always_comb begin
    y = '0;
    if (valid_q) begin
      case (sel_q)
        SEL_A:   y = a;
        SEL_B:   y = b;
        SEL_C:   y = c;
        default: y = d;
      endcase
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter. Expected values are hand
// derived from the arbitration rules. Build with MUX_ARB_TIMEOUT_EN to
// exercise the preemption variant (HOLD_MAX=4 here).
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] a, b, c, d;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       valid;
  logic [3:0] y;

  int errors = 0;
  int checks = 0;

  mux_rr_arbiter #(.DATA_W(4), .HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .grant (grant),
    .sel   (sel),
    .valid (valid),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge and settle 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Short reset pulse placed between clock edges
  task automatic doReset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    step();
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got=%b want=0000", grant); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("[TB] FAIL reset_valid got=%b want=0", valid); end
    checks++; if (sel !== 2'd0)      begin errors++; $display("[TB] FAIL reset_sel got=%0d want=0", sel); end
    checks++; if (y !== 4'h0)        begin errors++; $display("[TB] FAIL reset_y got=%h want=0", y); end
    rst = 1'b0;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL first_grant got=%b want=0001", grant); end
    checks++; if (sel !== 2'd0)      begin errors++; $display("[TB] FAIL first_sel got=%0d want=0", sel); end
    checks++; if (y !== 4'hA)        begin errors++; $display("[TB] FAIL first_y got=%h want=a", y); end
  endtask

  task automatic test_single();
    doReset();
    req = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL single_grant cyc=%0d got=%b want=0010", i, grant); end
      checks++; if (y !== 4'hB)        begin errors++; $display("[TB] FAIL single_y cyc=%0d got=%h want=b", i, y); end
    end
    req = 4'b0000;
    step();
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL release_grant got=%b want=0000", grant); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("[TB] FAIL release_valid got=%b want=0", valid); end
    checks++; if (y !== 4'h0)        begin errors++; $display("[TB] FAIL release_y got=%h want=0", y); end
    checks++; if (sel !== 2'd1)      begin errors++; $display("[TB] FAIL release_sel_kept got=%0d want=1", sel); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] expG [5];
    logic [3:0] expY [5];
    expG[0] = 4'b0001; expG[1] = 4'b0010; expG[2] = 4'b0100; expG[3] = 4'b1000; expG[4] = 4'b0001;
    expY[0] = 4'hA;    expY[1] = 4'hB;    expY[2] = 4'hC;    expY[3] = 4'hD;    expY[4] = 4'hA;
    doReset();
    req = 4'b1111;
    step();
    checks++; if (grant !== expG[0]) begin errors++; $display("[TB] FAIL rr_grant0 got=%b want=%b", grant, expG[0]); end
    for (int i = 1; i < 5; i++) begin
      req = 4'b1111 & ~expG[i-1];
      step();
      req = 4'b1111;
      checks++; if (grant !== expG[i]) begin errors++; $display("[TB] FAIL rr_grant%0d got=%b want=%b", i, grant, expG[i]); end
      checks++; if (valid !== 1'b1)    begin errors++; $display("[TB] FAIL rr_valid%0d got=%b want=1", i, valid); end
      checks++; if (y !== expY[i])     begin errors++; $display("[TB] FAIL rr_y%0d got=%h want=%h", i, y, expY[i]); end
    end
    req = 4'b0000;
    step();
  endtask

  task automatic test_pointer_order();
    doReset();
    req = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL ptr_first got=%b want=0100", grant); end
    req = 4'b1001;
    step();
    checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL ptr_handoff got=%b want=1000", grant); end
    checks++; if (sel !== 2'd3)      begin errors++; $display("[TB] FAIL ptr_sel got=%0d want=3", sel); end
    checks++; if (y !== 4'hD)        begin errors++; $display("[TB] FAIL ptr_y got=%h want=d", y); end
    req = 4'b0001;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL ptr_wrap got=%b want=0001", grant); end
    req = 4'b0000;
    step();
  endtask

`ifdef MUX_ARB_TIMEOUT_EN
  task automatic test_hold();
    logic [3:0] want;
    doReset();
    req = 4'b0011;
    for (int n = 0; n < 12; n++) begin
      step();
      want = (((n / 4) % 2) == 0) ? 4'b0001 : 4'b0010;
      checks++; if (grant !== want) begin errors++; $display("[TB] FAIL timeout_grant n=%0d got=%b want=%b", n, grant, want); end
    end
    req = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL sole_hold n=%0d got=%b want=0001", n, grant); end
    end
    req = 4'b0000;
    step();
  endtask
`else
  task automatic test_hold();
    doReset();
    req = 4'b0011;
    for (int n = 0; n < 12; n++) begin
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL nopreempt_grant n=%0d got=%b want=0001", n, grant); end
    end
    req = 4'b0000;
    step();
  endtask
`endif

  task automatic test_async_reset();
    doReset();
    req = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL areset_pre got=%b want=0100", grant); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL areset_grant got=%b want=0000", grant); end
    checks++; if (valid !== 1'b0)    begin errors++; $display("[TB] FAIL areset_valid got=%b want=0", valid); end
    checks++; if (y !== 4'h0)        begin errors++; $display("[TB] FAIL areset_y got=%h want=0", y); end
    rst = 1'b0;
    req = 4'b1111;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL areset_restart got=%b want=0001", grant); end
    req = 4'b0000;
    step();
  endtask

  // Scenario sequence
  initial begin
    rst = 1'b1;
    req = 4'b0000;
    a = 4'hA; b = 4'hB; c = 4'hC; d = 4'hD;
    test_reset();
    test_single();
    test_back_to_back();
    test_pointer_order();
    test_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
